// File: rtl/wfc_pkg.sv
// Shared types and default sizing for the weight fetch controller.
package wfc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2
  } wfc_state_e;

  localparam int unsigned WfcNumWeight = 5;
  localparam int unsigned WfcAddrWidth = 3;
  localparam int unsigned WfcDataWidth = 8;

endpackage

// File: rtl/wfc_skid_fifo.sv
// Two-entry FIFO between the weight memory read port and the weight stream.
// Simultaneous push and pop leaves the occupancy unchanged.
module wfc_skid_fifo #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == 2'd2);
  assign w_empty   = (r_count == 2'd0);
  // A push into a full FIFO is only legal when the head is leaving the same cycle.
  assign w_do_push = i_push && (!w_full || i_pop);
  assign w_do_pop  = i_pop && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_do_pop) begin
        r_rptr <= ~r_rptr;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = !w_empty;
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Fetches NUM_WEIGHT words from weight memory into a credit-limited stream.
// Define WEIGHT_FETCH_BASE_EN to add a base_addr input latched on start.
module weight_fetch_ctrl
  import wfc_pkg::*;
#(
  parameter int unsigned NUM_WEIGHT = WfcNumWeight,
  parameter int unsigned ADDR_WIDTH = WfcAddrWidth,
  parameter int unsigned DATA_WIDTH = WfcDataWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef WEIGHT_FETCH_BASE_EN
  input  logic [ADDR_WIDTH-1:0] base_addr,
`endif
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_radd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_last
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_WEIGHT - 1);

  wfc_state_e r_state;
  wfc_state_e w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_out;
  logic                  r_out_last;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] w_addr;

  logic                  w_fifo_valid;
  logic [DATA_WIDTH:0]   w_fifo_head;
  logic [1:0]            w_fifo_count;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_head_last;
  logic [2:0]            w_occ;
  logic [2:0]            w_lim;
  logic                  w_accept;

  assign w_accept    = (r_state == StIdle) && start;
  assign w_pop       = w_fifo_valid && w_ready;
  assign w_head_last = w_fifo_head[DATA_WIDTH];

  // Credit: buffered plus in-flight words, less the one leaving, must stay below two.
  assign w_occ   = {1'b0, w_fifo_count} + {2'b00, r_out};
  assign w_lim   = 3'd2 + {2'b00, w_pop};
  assign w_issue = (r_state == StFetch) && (w_occ < w_lim);

`ifdef WEIGHT_FETCH_BASE_EN
  logic [ADDR_WIDTH-1:0] r_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
    end else if (w_accept) begin
      r_base <= base_addr;
    end
  end

  assign w_addr = r_base + r_cnt;
`else
  assign w_addr = r_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt = StFetch;
        end
      end
      StFetch: begin
        if (w_issue && (r_cnt == LastIdx)) begin
          w_state_nxt = StDrain;
        end
      end
      StDrain: begin
        if (w_pop && w_head_last) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    busy     = (r_state != StIdle);
    done     = r_done;
    mem_ren  = w_issue;
    mem_radd = w_issue ? w_addr : '0;
    w_valid  = w_fifo_valid;
    w_data   = w_fifo_valid ? w_fifo_head[DATA_WIDTH-1:0] : '0;
    w_last   = w_fifo_valid && w_head_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_out      <= 1'b0;
      r_out_last <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
      end else if (w_issue) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_out      <= w_issue;
      r_out_last <= w_issue && (r_cnt == LastIdx);
      r_done     <= (r_state == StDrain) && w_pop && w_head_last;
    end
  end

  wfc_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_out),
    .i_data  ({r_out_last, mem_rdata}),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count)
  );

endmodule
